framebuffer_bank_controller: RTL

Double-buffered frame store and swap scheduler that feeds `display_driver`. A pixel writer (renderer, font blitter) fills the back bank through a valid/ready port while the driver scans the front bank by row/column address. The banks swap only on the driver's `frame_complete` pulse, so the panel never shows a partially written frame.

---
 rtl/framebuffer_bank_controller_pkg.sv | 19 +
 rtl/framebuffer_bank_controller_bank.sv | 26 ++
 rtl/framebuffer_bank_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/framebuffer_bank_controller_pkg.sv
// Shared definitions for the double-buffered frame store: FSM states and width helpers.
package framebuffer_bank_controller_pkg;

  typedef enum logic {
    FILL      = 1'b0,
    SWAP_WAIT = 1'b1
  } state_t;

  function automatic int unsigned pixel_width(input int unsigned bitwidth,
                                              input int unsigned segments);
    return 3 * bitwidth * segments;
  endfunction

  function automatic int unsigned addr_width(input int unsigned rows,
                                             input int unsigned columns);
    return $clog2(rows) + $clog2(columns);
  endfunction

endpackage

// File: rtl/framebuffer_bank_controller_bank.sv
// One frame bank: simple dual-port RAM, single write port, registered read port.
module framebuffer_bank #(
  parameter int unsigned width     = 24,
  parameter int unsigned addr_bits = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addr_bits-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [addr_bits-1:0] raddr,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem [0:(1 << addr_bits) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/framebuffer_bank_controller.sv
// Double-buffered frame store: writer fills the back bank, driver scans the front bank,
// banks swap only on the driver's end-of-frame pulse.
module framebuffer_bank_controller
  import framebuffer_bank_controller_pkg::*;
#(
  parameter int unsigned segments = 1,
  parameter int unsigned rows     = 8,
  parameter int unsigned columns  = 32,
  parameter int unsigned bitwidth = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         frame_complete,
  input  logic [$clog2(rows)-1:0]                      disp_row,
  input  logic [$clog2(columns)-1:0]                   disp_column,
  output logic [pixel_width(bitwidth, segments)-1:0]   disp_pixel,
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [$clog2(rows)-1:0]                      wr_row,
  input  logic [$clog2(columns)-1:0]                   wr_column,
  input  logic [pixel_width(bitwidth, segments)-1:0]   wr_data,
  input  logic                                         wr_last,
  output logic                                         front_bank,
  output logic                                         swap_pending,
  output logic                                         blank,
  output logic [15:0]                                  frame_count
);

  localparam int unsigned pw = pixel_width(bitwidth, segments);
  localparam int unsigned aw = addr_width(rows, columns);

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            swap;
  logic [aw-1:0]   waddr;
  logic [aw-1:0]   raddr;
  logic [pw-1:0]   rdata0;
  logic [pw-1:0]   rdata1;

  assign waddr  = {wr_row, wr_column};
  assign raddr  = {disp_row, disp_column};
  assign accept = wr_valid && wr_ready;
  assign swap   = (state == SWAP_WAIT) && frame_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:      if (accept && wr_last) state_next = SWAP_WAIT;
      SWAP_WAIT: if (frame_complete)    state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  always_comb begin
    wr_ready     = (state == FILL) && !rst;
    swap_pending = (state == SWAP_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank  <= 1'b0;
      blank       <= 1'b1;
      frame_count <= '0;
    end else if (swap) begin
      front_bank  <= ~front_bank;
      blank       <= 1'b0;
      frame_count <= frame_count + 16'd1;
    end
  end

  framebuffer_bank #(
    .width     (pw),
    .addr_bits (aw)
  ) u_bank0 (
    .clk   (clk),
    .we    (accept && front_bank),
    .waddr (waddr),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata0)
  );

  framebuffer_bank #(
    .width     (pw),
    .addr_bits (aw)
  ) u_bank1 (
    .clk   (clk),
    .we    (accept && !front_bank),
    .waddr (waddr),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata1)
  );

  // Both banks are read every cycle; selecting after the registers lets the swap take
  // effect on the very next read without a second pipeline stage.
  always_comb begin
    disp_pixel = '0;
    if (!blank) begin
      disp_pixel = front_bank ? rdata1 : rdata0;
    end
  end

endmodule
